// File: rtl/img_frame_gen.sv
// rtl/img_frame_gen.sv - parallel-interface image frame transmitter with decrementing pixel pattern
//
// Emits one frame (img_fv / img_lv / img_d) per level change on cmd_frame.
// Pixels start at PixelInitial on every frame and decrement modulo 4096,
// continuing across line boundaries.
//
// Ports:
//   clk                sole clock, outputs launched on its rising edge
//   rst_               asynchronous active-low reset
//   cmd_frame          toggle command, each level change requests one frame
//   img_fv             frame valid
//   img_lv             line valid
//   img_d              pixel data, 0 whenever img_lv is low
//   status_busy        high while a frame is being emitted
//   status_frameDone   toggles once per completed frame
//   status_pixelCount  pixels emitted in the current or last frame
module img_frame_gen #(
   parameter int          ImgWidth     = 2304,
   parameter int          ImgHeight    = 1296,
   parameter int          FvToLv       = 4,
   parameter int          LineBlank    = 8,
   parameter int          LvToFv       = 4,
   parameter logic [11:0] PixelInitial = 12'hFFF
) (
   input  logic                                        clk,
   input  logic                                        rst_,
   input  logic                                        cmd_frame,
   output logic                                        img_fv,
   output logic                                        img_lv,
   output logic [11:0]                                 img_d,
   output logic                                        status_busy,
   output logic                                        status_frameDone,
   output logic [$clog2(ImgWidth*ImgHeight+1)-1:0]     status_pixelCount
);

   localparam int PcW   = $clog2(ImgWidth*ImgHeight+1);
   localparam int ColW  = (ImgWidth  > 1) ? $clog2(ImgWidth)  : 1;
   localparam int RowW  = (ImgHeight > 1) ? $clog2(ImgHeight) : 1;
   localparam int PhMax = (FvToLv > LineBlank) ?
                          ((FvToLv > LvToFv) ? FvToLv : LvToFv) :
                          ((LineBlank > LvToFv) ? LineBlank : LvToFv);
   localparam int PhW   = (PhMax > 1) ? $clog2(PhMax) : 1;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_PRE,
      ST_LINE,
      ST_BLANK,
      ST_POST
   } state_t;

   state_t          state, state_n;
   logic            ack, ack_n;
   logic [PhW-1:0]  cnt, cnt_n;
   logic [ColW-1:0] col, col_n;
   logic [RowW-1:0] row, row_n;
   logic [11:0]     pix, pix_n;
   logic [PcW-1:0]  pc, pc_n;
   logic            done, done_n;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state <= ST_INIT;
         ack   <= 1'b0;
         cnt   <= '0;
         col   <= '0;
         row   <= '0;
         pix   <= '0;
         pc    <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         ack   <= ack_n;
         cnt   <= cnt_n;
         col   <= col_n;
         row   <= row_n;
         pix   <= pix_n;
         pc    <= pc_n;
         done  <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      ack_n   = ack;
      cnt_n   = cnt;
      col_n   = col;
      row_n   = row;
      pix_n   = pix;
      pc_n    = pc;
      done_n  = done;
      unique case (state)
         // Absorb whatever toggle level is present at reset release.
         ST_INIT: begin
            ack_n   = cmd_frame;
            state_n = ST_IDLE;
         end
         ST_IDLE: begin
            if (cmd_frame != ack) begin
               ack_n   = cmd_frame;
               pc_n    = '0;
               pix_n   = PixelInitial;
               cnt_n   = '0;
               state_n = ST_PRE;
            end
         end
         ST_PRE: begin
            if (cnt == PhW'(FvToLv - 1)) begin
               col_n   = '0;
               row_n   = '0;
               state_n = ST_LINE;
            end else begin
               cnt_n = cnt + PhW'(1);
            end
         end
         ST_LINE: begin
            pix_n = pix - 12'd1;
            pc_n  = pc + PcW'(1);
            if (col == ColW'(ImgWidth - 1)) begin
               cnt_n = '0;
               if (row == RowW'(ImgHeight - 1)) begin
                  state_n = ST_POST;
               end else begin
                  row_n   = row + RowW'(1);
                  state_n = ST_BLANK;
               end
            end else begin
               col_n = col + ColW'(1);
            end
         end
         ST_BLANK: begin
            if (cnt == PhW'(LineBlank - 1)) begin
               col_n   = '0;
               state_n = ST_LINE;
            end else begin
               cnt_n = cnt + PhW'(1);
            end
         end
         ST_POST: begin
            if (cnt == PhW'(LvToFv - 1)) begin
               done_n  = ~done;
               state_n = ST_IDLE;
            end else begin
               cnt_n = cnt + PhW'(1);
            end
         end
         default: state_n = ST_INIT;
      endcase
   end

   // Outputs decode only registered state, so they change solely on clk
   // edges and drop together with the asynchronous reset.
   assign img_fv            = (state == ST_PRE) || (state == ST_LINE) ||
                              (state == ST_BLANK) || (state == ST_POST);
   assign img_lv            = (state == ST_LINE);
   assign img_d             = (state == ST_LINE) ? pix : 12'h000;
   assign status_busy       = img_fv;
   assign status_frameDone  = done;
   assign status_pixelCount = pc;

endmodule

// File: tb/tb_img_frame_gen.sv
// tb/tb_img_frame_gen.sv - self-checking bench for img_frame_gen
module tb_img_frame_gen;

   logic        clk;
   logic        rst_;
   logic        cmd;
   logic        fv, lv, busy, done;
   logic [11:0] d;
   logic [3:0]  pc;
   logic        fv_w, lv_w, busy_w, done_w;
   logic [11:0] d_w;
   logic [3:0]  pc_w;

   int n_checks;
   int n_fail;

   img_frame_gen #(
      .ImgWidth(4), .ImgHeight(3), .FvToLv(3), .LineBlank(2), .LvToFv(2),
      .PixelInitial(12'hFFF)
   ) dut (
      .clk(clk), .rst_(rst_), .cmd_frame(cmd),
      .img_fv(fv), .img_lv(lv), .img_d(d),
      .status_busy(busy), .status_frameDone(done), .status_pixelCount(pc)
   );

   img_frame_gen #(
      .ImgWidth(4), .ImgHeight(3), .FvToLv(3), .LineBlank(2), .LvToFv(2),
      .PixelInitial(12'h002)
   ) dut_w (
      .clk(clk), .rst_(rst_), .cmd_frame(cmd),
      .img_fv(fv_w), .img_lv(lv_w), .img_d(d_w),
      .status_busy(busy_w), .status_frameDone(done_w), .status_pixelCount(pc_w)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        fv;
      logic        lv;
      logic [11:0] d;
      logic [11:0] dw;
      logic [3:0]  pc;
   } exp_t;

   exp_t tbl[22];

   function automatic exp_t mk(input logic f, input logic l, input logic [11:0] dd,
                               input logic [11:0] ddw, input logic [3:0] p);
      exp_t e;
      e.fv = f; e.lv = l; e.d = dd; e.dw = ddw; e.pc = p;
      return e;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   // Cycle 0 is the first negedge after the edge that starts the frame.
   task automatic run_frame(input int tog_a, input int tog_b);
      logic d0, nd0;
      d0  = done;
      nd0 = ~d0;
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         chk("fv",   i, fv,   tbl[i].fv);
         chk("lv",   i, lv,   tbl[i].lv);
         chk("d",    i, d,    tbl[i].d);
         chk("busy", i, busy, tbl[i].fv);
         chk("pc",   i, pc,   tbl[i].pc);
         chk("fv_w", i, fv_w, tbl[i].fv);
         chk("d_w",  i, d_w,  tbl[i].dw);
         if (i == 20) chk("done_hold", i, done, d0);
         if (i == 21) chk("done_toggle", i, done, nd0);
         if (i == tog_a || i == tog_b) cmd = ~cmd;
      end
   endtask

   initial begin
      logic dsave;
      n_checks = 0;
      n_fail   = 0;

      tbl[0]  = mk(1'b1, 1'b0, 12'h000, 12'h000, 4'd0);
      tbl[1]  = mk(1'b1, 1'b0, 12'h000, 12'h000, 4'd0);
      tbl[2]  = mk(1'b1, 1'b0, 12'h000, 12'h000, 4'd0);
      tbl[3]  = mk(1'b1, 1'b1, 12'hFFF, 12'h002, 4'd0);
      tbl[4]  = mk(1'b1, 1'b1, 12'hFFE, 12'h001, 4'd1);
      tbl[5]  = mk(1'b1, 1'b1, 12'hFFD, 12'h000, 4'd2);
      tbl[6]  = mk(1'b1, 1'b1, 12'hFFC, 12'hFFF, 4'd3);
      tbl[7]  = mk(1'b1, 1'b0, 12'h000, 12'h000, 4'd4);
      tbl[8]  = mk(1'b1, 1'b0, 12'h000, 12'h000, 4'd4);
      tbl[9]  = mk(1'b1, 1'b1, 12'hFFB, 12'hFFE, 4'd4);
      tbl[10] = mk(1'b1, 1'b1, 12'hFFA, 12'hFFD, 4'd5);
      tbl[11] = mk(1'b1, 1'b1, 12'hFF9, 12'hFFC, 4'd6);
      tbl[12] = mk(1'b1, 1'b1, 12'hFF8, 12'hFFB, 4'd7);
      tbl[13] = mk(1'b1, 1'b0, 12'h000, 12'h000, 4'd8);
      tbl[14] = mk(1'b1, 1'b0, 12'h000, 12'h000, 4'd8);
      tbl[15] = mk(1'b1, 1'b1, 12'hFF7, 12'hFFA, 4'd8);
      tbl[16] = mk(1'b1, 1'b1, 12'hFF6, 12'hFF9, 4'd9);
      tbl[17] = mk(1'b1, 1'b1, 12'hFF5, 12'hFF8, 4'd10);
      tbl[18] = mk(1'b1, 1'b1, 12'hFF4, 12'hFF7, 4'd11);
      tbl[19] = mk(1'b1, 1'b0, 12'h000, 12'h000, 4'd12);
      tbl[20] = mk(1'b1, 1'b0, 12'h000, 12'h000, 4'd12);
      tbl[21] = mk(1'b0, 1'b0, 12'h000, 12'h000, 4'd12);

      rst_ = 1'b0;
      cmd  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_fv",   0, fv,   0);
      chk("rst_lv",   0, lv,   0);
      chk("rst_d",    0, d,    0);
      chk("rst_busy", 0, busy, 0);
      chk("rst_done", 0, done, 0);
      chk("rst_pc",   0, pc,   0);
      rst_ = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_fv", 0, fv, 0);

      // Single frame, then a back-to-back restart from the Idle cycle.
      cmd = ~cmd;
      run_frame(-1, -1);
      cmd = ~cmd;
      run_frame(-1, -1);

      // One toggle mid-frame: exactly one follow-on frame after one idle cycle.
      cmd = ~cmd;
      run_frame(5, -1);
      run_frame(-1, -1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("no_third_frame", i, fv, 0);
      end

      // Two toggles mid-frame cancel.
      cmd = ~cmd;
      run_frame(5, 9);
      dsave = done;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         chk("even_no_frame", i, fv, 0);
         chk("even_done", i, done, dsave);
      end

      // Reset during line 2.
      cmd = ~cmd;
      for (int i = 0; i < 11; i++) @(negedge clk);
      chk("pre_rst_lv", 10, lv, 1);
      chk("pre_rst_d",  10, d,  12'hFFA);
      #2 rst_ = 1'b0;
      #1;
      chk("mid_rst_fv",   0, fv,   0);
      chk("mid_rst_lv",   0, lv,   0);
      chk("mid_rst_d",    0, d,    0);
      chk("mid_rst_busy", 0, busy, 0);
      chk("mid_rst_done", 0, done, 0);
      chk("mid_rst_pc",   0, pc,   0);
      cmd = 1'b1;
      repeat (2) @(negedge clk);
      rst_ = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("post_rst_no_frame", i, fv, 0);
         chk("post_rst_busy", i, busy, 0);
      end
      cmd = 1'b0;
      run_frame(-1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/img_frame_gen.md
# img_frame_gen

Synthesizable image-sensor transmitter. Emits frames on the same parallel pixel interface that ImgController captures: `img_fv`, `img_lv` and 12-bit `img_d`, with a deterministic decrementing pixel pattern. Used for on-FPGA loopback into ImgController and for hardware bring-up without a sensor. Its output pattern is exactly the one PixelValidator checks on readout.

## Interface
- `ImgWidth`, 2304: pixels per line; must be ≥1.
- `ImgHeight`, 1296: lines per frame; must be ≥1.
- `FvToLv`, 4: cycles with `img_fv`=1 and `img_lv`=0 before the first line; must be ≥1.
- `LineBlank`, 8: cycles with `img_lv`=0 between consecutive lines; must be ≥1.
- `LvToFv`, 4: cycles with `img_fv`=1 and `img_lv`=0 after the last line; must be ≥1.
- `PixelInitial`, 12'hFFF: value of the first pixel of every frame.
- `clk`  in  1  sole clock; all outputs are launched on its rising edge.
- `rst_`  in  1  asynchronous, active-low reset.
- `cmd_frame`  in  1  toggle command: each level change requests one frame.
- `img_fv`  out  1  frame valid.
- `img_lv`  out  1  line valid.
- `img_d`  out  12  pixel data; valid only while `img_lv`=1, otherwise 0.
- `status_busy`  out  1  high from frame start until `img_fv` falls.
- `status_frameDone`  out  1  toggles once per completed frame.
- `status_pixelCount`  out  $clog2(ImgWidth*ImgHeight+1)  pixels emitted in the current or last frame.

## Operation
- Reset (asynchronous, active-low) forces all of the following, immediately:
  - every output to 0;
  - FSM to Init;
  - the acknowledge register `ack` to 0.
- States and transitions:
  - Init: lasts one cycle. Loads `ack` ← `cmd_frame`, so a toggle level present at reset never starts a frame. Goes to Idle.
  - Idle: if `cmd_frame` ≠ `ack`, then `ack` ← `cmd_frame`, clear `status_pixelCount`, load pixel register with `PixelInitial`, and go to Pre. Otherwise stay in Idle.
  - Pre: `img_fv`=1, `img_lv`=0 for `FvToLv` cycles, then go to Line.
  - Line: `img_lv`=1 for `ImgWidth` cycles. Each cycle:
    - `img_d` = pixel register;
    - pixel register decrements by 1, modulo 4096 (0x000 → 0xFFF, no saturation);
    - `status_pixelCount` increments by 1.
    - Pixel values continue across line boundaries; they do not restart per line.
    - After the last column: go to Blank if this is not the last line, else to Post.
  - Blank: `img_lv`=0 for `LineBlank` cycles, then go to Line.
  - Post: `img_fv`=1, `img_lv`=0 for `LvToFv` cycles. After these cycles, `img_fv`→0, `status_busy`→0, `status_frameDone` toggles, and the FSM returns to Idle.
- Commands while busy:
  - Toggles on `cmd_frame` are not acted on mid-frame.
  - Idle compares `cmd_frame` against `ack`, so an odd number of toggles during a frame yields exactly one further frame.
  - An even number of toggles during a frame yields none (the toggles cancel).
- Counters:
  - column counter: $clog2(ImgWidth) bits;
  - row counter: $clog2(ImgHeight) bits;
  - one shared blank/phase counter, sized to the maximum of `FvToLv`, `LineBlank`, `LvToFv`.
- `status_pixelCount` holds its final value (`ImgWidth*ImgHeight`) until the next frame starts.

## Timing
- Start latency: a toggle that is stable before rising edge k, with the FSM in Idle, gives `img_fv`=1 and `status_busy`=1 after edge k.
- `img_fv` high time is exactly `FvToLv + ImgHeight*ImgWidth + (ImgHeight-1)*LineBlank + LvToFv` cycles.
- `img_lv` pulses:
  - exactly `ImgHeight` pulses per frame;
  - each exactly `ImgWidth` cycles;
  - never asserted while `img_fv`=0.
- `img_d` changes only on `clk` edges. It is 0 whenever `img_lv`=0, including during blanking.
- Falling edge of `img_fv`, the 0 on `status_busy` and the `status_frameDone` toggle all occur on the same edge.
- Back-to-back frames: `img_fv` stays low for at least 1 cycle (the Idle cycle).
- Reset asserted mid-frame: `img_fv`, `img_lv`, `img_d` drop asynchronously, with no `status_frameDone` toggle. The next frame after release requires a fresh toggle, which Init guarantees.

## Test plan
Parameters for all scenarios unless stated: W=4, H=3, FvToLv=3, LineBlank=2, LvToFv=2.
- Single frame:
  - Stimulus: one toggle after reset release.
  - Response: `img_fv` high for 21 cycles, 3 `img_lv` pulses of 4 cycles, pixels 0xFFF down to 0xFF4 in order, `status_pixelCount`=12, `status_frameDone` toggles once.
- Pattern restart:
  - Stimulus: a second toggle after the first frame completes.
  - Response: the first pixel is again 0xFFF and the sequence is identical to the first frame.
- Wrap-around:
  - Stimulus: `PixelInitial`=12'h002.
  - Response: pixels 0x002, 0x001, 0x000, 0xFFF, 0xFFE, …, 0xFF7.
- Toggles during a frame:
  - Stimulus A: one toggle mid-frame. Response: a second frame starts after exactly 1 idle cycle.
  - Stimulus B: two toggles mid-frame. Response: no second frame; `status_frameDone` toggles only once.
- Reset mid-frame:
  - Stimulus: assert `rst_` during line 2.
  - Response: all outputs are 0 immediately; no frame follows release even with `cmd_frame`=1; a subsequent toggle produces a complete, correct frame.
- Full-size regression:
  - Stimulus: default parameters, frame fed through ImgController capture.
  - Response: `status_capturePixelCount` = 2304×1296.
